tdm_demux: RTL
==============

# tdm_demux

Receive-side companion to the four-channel 2-bit selector. Upstream, a free-running `sel` cycles the selector through channels a, b, c, d, serializing them onto one lane. This block takes that lane plus a frame-sync marker and recovers the four channels into registered outputs. All four outputs update together once per complete frame, and the block flags framing errors.

## Interface
Parameters:
- `WIDTH`, default 2: lane and channel data width.
- `TIMEOUT`, default 15: idle-cycle limit for the optional timeout (see Configuration). Legal range 1..255.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `din`, in, WIDTH: serialized channel data.
- `din_valid`, in, 1: `din` holds a beat this cycle.
- `sync`, in, 1: marks the beat as slot 0 (channel a). Qualified by `din_valid`.
- `a`, `b`, `c`, `d`, out, WIDTH each: recovered channels, registered.
- `frame_valid`, out, 1: one-cycle pulse when a..d have just been updated.
- `frame_err`, out, 1: one-cycle pulse on a framing violation.
- `locked`, out, 1: high in state LOCKED.
- `slot`, out, 2: slot index expected for the next beat. Debug and monitoring only.

## Operation
- Reset values: a=b=c=d=0, frame_valid=0, frame_err=0, locked=0, slot=0, state=HUNT, shadow registers=0.
- Beat: any cycle with `din_valid`=1. Cycles without a beat change nothing except the optional idle counter.

States:
- HUNT: beats without `sync` are discarded. A beat with `sync` stores `din` into shadow[0], sets slot=1 and moves to LOCKED.
- LOCKED, slot=0, beat with `sync`: store into shadow[0], slot=1.
- LOCKED, slot=0, beat without `sync`: pulse frame_err, discard the beat, go to HUNT with slot=0.
- LOCKED, slot 1..3, beat without `sync`: store into shadow[slot]. Slot advances, wrapping 3 to 0.
- LOCKED, slot 1..3, beat with `sync`: pulse frame_err and discard the partial frame. Treat this beat as a new slot 0: store into shadow[0], slot=1, stay LOCKED.
- Slot-3 store: on the next edge, a..d are loaded from shadow[0..2] and the slot-3 beat, all at once. frame_valid pulses on that same edge.
- Outputs a..d change only with frame_valid. A partial or discarded frame never reaches a..d.
- Channel mapping: slot 0→a, 1→b, 2→c, 3→d. This matches selector codes 0..3.
- The shadow registers never need clearing; every published frame overwrites all four.

## Timing
- Latency: a..d and frame_valid are valid the cycle after the slot-3 beat edge, which is 1 clock.
- Back-to-back frames at full rate (din_valid=1 every cycle) give frame_valid once every 4 cycles with no gaps.
- frame_err is registered and rises one cycle after the offending beat. It never coincides with frame_valid for the same beat.
- Reset mid-frame: asserting rst_n=0 immediately returns every output to its reset value. The partial frame is lost, and after reset the block hunts for `sync`.
- `locked` and `slot` are registered state and change on the beat edge.

## Configuration
- `TDM_DEMUX_TIMEOUT_EN` defined:
  - An 8-bit idle counter counts consecutive non-beat cycles while LOCKED and slot≠0.
  - When the count reaches TIMEOUT: pulse frame_err, discard the partial frame, go to HUNT, slot=0.
  - Any beat clears the counter. The counter is held at 0 in HUNT and when slot=0.
- Not defined: no counter logic. A stalled lane waits indefinitely mid-frame.

## Structure
- Shared package `tdm_pkg` holds:
  - state encoding `HUNT`=1'b0, `LOCKED`=1'b1
  - slot constants `SLOT_A`..`SLOT_D` = 0..3
  - default `WIDTH`
- The upstream serializer reuses the same package.
- No sub-module is needed: the FSM, slot counter and shadow/output registers sit in one module.
- Timeout counter sits inside the macro guard.

## Test plan
- Reset, then beats 1 (sync), 2, 3, 0 → one cycle later a=1, b=2, c=3, d=0, frame_valid=1 for exactly one cycle, locked=1.
- 8 consecutive beats, sync on beats 0 and 4, data 0,1,2,3,3,2,1,0 → frame_valid on cycles 4 and 8, second frame a=3, b=2, c=1, d=0.
- Beats without sync while in HUNT: data 3,3,3, then sync+1 → no frame_valid, no frame_err, and a..d stay 0 until the frame started by the sync beat completes.
- sync on the slot-2 beat (LOCKED) → frame_err pulse, a..d unchanged, slot=1 afterwards, and the next three beats complete a frame.
- Slot-0 beat without sync while LOCKED → frame_err, locked=0, slot=0.
- Macro defined, TIMEOUT=3: after sync+1, beat 2, then 3 idle cycles → frame_err, locked=0. Macro undefined, same stimulus → no error, and frame completes after the late beats.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM selector / demux pair: FSM state encoding,
// slot constants and the default lane width.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;

  localparam int unsigned DEFAULT_WIDTH = 2;

endpackage

// File: rtl/tdm_demux.sv
// Four-channel TDM demultiplexer: recovers channels a..d from a serialized
// lane using a slot-0 sync marker, publishing all four at once per frame.
// Optional idle timeout mid-frame: define TDM_DEMUX_TIMEOUT_EN.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             frame_valid,
  output logic             frame_err,
  output logic             locked,
  output logic [1:0]       slot
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("tdm_demux: TIMEOUT must be in 1..255");
  end

  state_t           state, state_n;
  logic [1:0]       slot_n;
  logic [WIDTH-1:0] sh_a, sh_b, sh_c;
  logic             store;
  logic [1:0]       store_idx;
  logic             publish;
  logic             err;
  logic             timeout_hit;

`ifdef TDM_DEMUX_TIMEOUT_EN
  logic [7:0] idle;

  assign timeout_hit = (state == LOCKED) && (slot != SLOT_A) && !din_valid &&
                       (idle == 8'(TIMEOUT - 1));

  // Consecutive idle cycles while mid-frame; cleared by any beat or outside a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle <= '0;
    end else if (din_valid || state == HUNT || slot == SLOT_A || timeout_hit) begin
      idle <= '0;
    end else begin
      idle <= idle + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next state, slot and shadow/publish control for each beat.
  always_comb begin
    state_n   = state;
    slot_n    = slot;
    store     = 1'b0;
    store_idx = SLOT_A;
    publish   = 1'b0;
    err       = 1'b0;
    if (din_valid) begin
      case (state)
        HUNT: begin
          if (sync) begin
            store   = 1'b1;
            slot_n  = SLOT_B;
            state_n = LOCKED;
          end
        end
        LOCKED: begin
          if (sync) begin
            // A sync mid-frame aborts the partial frame but itself starts a new one.
            err    = (slot != SLOT_A);
            store  = 1'b1;
            slot_n = SLOT_B;
          end else if (slot == SLOT_A) begin
            err     = 1'b1;
            state_n = HUNT;
            slot_n  = SLOT_A;
          end else begin
            slot_n = slot + 2'd1;
            if (slot == SLOT_D) begin
              publish = 1'b1;
            end else begin
              store     = 1'b1;
              store_idx = slot;
            end
          end
        end
        default: begin
          state_n = HUNT;
          slot_n  = SLOT_A;
        end
      endcase
    end else if (timeout_hit) begin
      err     = 1'b1;
      state_n = HUNT;
      slot_n  = SLOT_A;
    end
  end

  // FSM state and slot counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      slot  <= SLOT_A;
    end else begin
      state <= state_n;
      slot  <= slot_n;
    end
  end

  // Shadow registers for slots 0..2; slot 3 goes straight to d on publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a <= '0;
      sh_b <= '0;
      sh_c <= '0;
    end else if (store) begin
      case (store_idx)
        SLOT_A:  sh_a <= din;
        SLOT_B:  sh_b <= din;
        default: sh_c <= din;
      endcase
    end
  end

  // Published channels and the one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a           <= '0;
      b           <= '0;
      c           <= '0;
      d           <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= publish;
      frame_err   <= err;
      if (publish) begin
        a <= sh_a;
        b <= sh_b;
        c <= sh_c;
        d <= din;
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule
